booth_seq_mul: RTL and testbench

Parametrised radix-4 Booth sequential multiplier; successor to the team's shift-add multiplier. Multiplies two N-bit operands as signed or unsigned (selected per operation), retiring two multiplier bits per cycle and roughly halving latency. Sits as a multi-cycle arithmetic unit behind a Start/Done handshake, with a Busy flag for back-pressure and a held result register.

---
 rtl/booth_seq_mul_if.sv | 33 +++
 rtl/booth_seq_mul.sv | 119 +++++++++++
 tb/tb_booth_seq_mul.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/booth_seq_mul_if.sv
//==============================================================================
// Module      : booth_seq_mul_if
// Description : Start/Done/Busy handshake and operand/result bus for the
//               radix-4 Booth sequential multiplier.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface booth_seq_mul_if #(
  parameter int N = 8
);
  logic           start;
  logic           is_signed;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2*N-1:0] r;
  logic           done;
  logic           busy;

  // Requester side: issues operations, observes result and status
  modport master (
    output start, is_signed, a, b,
    input  r, done, busy
  );

  // Multiplier side
  modport slave (
    input  start, is_signed, a, b,
    output r, done, busy
  );
endinterface

`default_nettype wire

// File: rtl/booth_seq_mul.sv
//==============================================================================
// Module      : booth_seq_mul
// Description : Radix-4 Booth sequential multiplier, signed or unsigned per
//               operation, two multiplier bits retired per cycle. Result is
//               held in R until the next completion.
//               Optional macro BOOTH_EARLY_EXIT_EN: finish as soon as every
//               remaining Booth digit is zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module booth_seq_mul #(
  parameter int N = 8              // operand width, even and >= 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  booth_seq_mul_if.slave  bus
);

  localparam int EW = N + 2;       // extended operand width
  localparam int AW = 2 * N + 2;   // accumulator width
  localparam int ND = N / 2 + 1;   // number of Booth digits
  localparam int CW = $clog2(ND + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [EW-1:0]   mult;           // multiplier, arithmetic-shifted right by 2
  logic            prev;           // b[2i-1] for the current digit
  logic [AW-1:0]   mcand_sh;       // multiplicand pre-shifted to weight 4^i
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [2*N-1:0]  r_q;
  logic            done_q;
  logic            busy_q;

  logic [2:0]      triplet;
  logic [AW-1:0]   partial;
  logic [AW-1:0]   acc_sum;
  logic            early;
  logic            last_digit;

  assign bus.r    = r_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

  // Booth recoding of the current triplet into a partial product
  always_comb begin
    triplet = {mult[1:0], prev};
    partial = '0;
    case (triplet)
      3'b001, 3'b010: partial = mcand_sh;
      3'b011:         partial = mcand_sh << 1;
      3'b100:         partial = -(mcand_sh << 1);
      3'b101, 3'b110: partial = -mcand_sh;
      default:        partial = '0;
    endcase
    acc_sum = acc + partial;
  end

`ifdef BOOTH_EARLY_EXIT_EN
  // Remaining bits from 2i+1 upward all equal => every later digit is zero
  assign early = (&mult[EW-1:1]) | ~(|mult[EW-1:1]);
`else
  assign early = 1'b0;
`endif

  assign last_digit = (cnt == CW'(1)) || early;

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mult     <= '0;
      prev     <= 1'b0;
      mcand_sh <= '0;
      acc      <= '0;
      cnt      <= '0;
      r_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mult     <= {{2{bus.is_signed & bus.b[N-1]}}, bus.b};
            mcand_sh <= {{(AW-N){bus.is_signed & bus.a[N-1]}}, bus.a};
            prev     <= 1'b0;
            acc      <= '0;
            cnt      <= CW'(ND);
            busy_q   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc      <= acc_sum;
          mult     <= {mult[EW-1], mult[EW-1], mult[EW-1:2]};
          prev     <= mult[1];
          mcand_sh <= mcand_sh << 2;
          cnt      <= cnt - CW'(1);
          if (last_digit) begin
            r_q    <= acc_sum[2*N-1:0];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_mul.sv
//==============================================================================
// Module      : tb_booth_seq_mul
// Description : Directed bench for booth_seq_mul at N=8.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_booth_seq_mul;

  localparam int N = 8;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  booth_seq_mul_if #(.N(N)) bus ();

  booth_seq_mul #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected latency: early-exit value when the feature is built in
  function automatic int lat(input int full, input int early_lat);
`ifdef BOOTH_EARLY_EXIT_EN
    return early_lat;
`else
    return full;
`endif
  endfunction

  // Called at #1 after the edge that sampled Start; returns observed latency
  task automatic finish_op(input string tag, input logic [15:0] hold_r, output int l);
    l = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        l = k;
        break;
      end
      check({tag, "_busy"}, 64'(bus.busy), 64'd1);
      check({tag, "_hold"}, 64'(bus.r), 64'(hold_r));
    end
    if (l == 0) check({tag, "_timeout"}, 64'(bus.done), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp_r, input int exp_lat);
    logic [15:0] hold;
    int l;
    hold = bus.r;
    bus.a = a; bus.b = b; bus.is_signed = s; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.is_signed = ~s;
    finish_op(tag, hold, l);
    check({tag, "_r"}, 64'(bus.r), 64'(exp_r));
    check({tag, "_lat"}, 64'(l), 64'(exp_lat));
    check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [15:0] hold;
    int          l;
    logic [7:0]  ra, rb;
    logic        rs;
    int          pa, pb;
    logic [31:0] prod;
    logic        lat_ok;

    compared = 0; mismatched = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_r", 64'(bus.r), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Unsigned full-scale
    run_op("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, lat(5, 5));
    @(posedge clk); #1;
    check("done_one_cycle", 64'(bus.done), 64'd0);

    // Signed corners
    run_op("s80x80", 8'h80, 8'h80, 1'b1, 16'h4000, lat(5, 4));
    run_op("sFFx7F", 8'hFF, 8'h7F, 1'b1, 16'hFF81, lat(5, 4));
    run_op("s7Fx80", 8'h7F, 8'h80, 1'b1, 16'hC080, lat(5, 4));

    // Start held high through a run, then accepted in the Done cycle
    hold = bus.r;
    bus.a = 8'd3; bus.b = 8'd7; bus.is_signed = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = 8'h55; bus.b = 8'h66;
    finish_op("held1", hold, l);
    check("held1_r", 64'(bus.r), 64'd21);
    check("held1_lat", 64'(l), 64'(lat(5, 2)));
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("held2_busy_start", 64'(bus.busy), 64'd1);
    finish_op("held2", 16'd21, l);
    check("held2_r", 64'(bus.r), 64'h21DE);
    check("held2_lat", 64'(l), 64'(lat(5, 4)));

    // Reset two cycles into a run
    bus.a = 8'd3; bus.b = 8'd7; bus.is_signed = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_r", 64'(bus.r), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    l = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) l++;
    end
    check("abort_no_done", 64'(l), 64'd0);
    run_op("u3x7", 8'd3, 8'd7, 1'b0, 16'd21, lat(5, 2));

    // Early-exit vectors (fixed latency when the feature is absent)
    run_op("u9x1", 8'd9, 8'd1, 1'b0, 16'd9, lat(5, 1));
    run_op("s5xFF", 8'd5, 8'hFF, 1'b1, 16'hFFFB, lat(5, 1));
    run_op("u2xFF", 8'd2, 8'hFF, 1'b0, 16'h01FE, lat(5, 5));
    run_op("u0x0", 8'd0, 8'd0, 1'b0, 16'd0, lat(5, 1));
    run_op("sFFxFF", 8'hFF, 8'hFF, 1'b1, 16'd1, lat(5, 1));

    // Random vectors against an integer model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      pa = rs ? int'($signed(ra)) : int'(ra);
      pb = rs ? int'($signed(rb)) : int'(rb);
      prod = 32'(pa * pb);
      hold = bus.r;
      bus.a = ra; bus.b = rb; bus.is_signed = rs; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      finish_op("rnd", hold, l);
      check("rnd_r", 64'(bus.r), 64'(prod[15:0]));
`ifdef BOOTH_EARLY_EXIT_EN
      lat_ok = (l >= 1) && (l <= 5);
`else
      lat_ok = (l == 5);
`endif
      check("rnd_lat", 64'(lat_ok), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
